pr_arb: RTL and testbench
=========================

PR_ARB -- requirements
Module: pr_arb

Interface
REQ-001 Parameter CP_STARVE, default 4, meaning the maximum number of consecutive CPU grants while a panel request waits.
REQ-002 clk_sys  in  1  system clock; all state changes on the rising edge.
REQ-003 clm_  in  1  reset, asynchronous, active-low.
REQ-004 blr_  in  1  register block; low inhibits new grants.
REQ-005 cpu_req  in  1  CPU access request, level.
REQ-006 cpu_we  in  1  CPU write (1) / read (0).
REQ-007 cpu_reg  in  3  CPU register index R0..R7.
REQ-008 cpu_wdata  in  16  CPU write data.
REQ-009 cpu_ack  out  1  CPU access complete, one-cycle pulse.
REQ-010 cp_req, cp_we, cp_reg[3], cp_wdata[16], cp_ack: control-panel port, same directions, widths and meanings as the CPU port.
REQ-011 l  in  16  register file read bus L.
REQ-012 w  out  16  write data driven onto bus W.
REQ-013 ra_, rb_, rc_  out  1 each  register select, active-low; index = {~rc_,~rb_,~ra_}.
REQ-014 w_r_  out  1  write enable, active-low.
REQ-015 strob1_  out  1  register strobe, active-low.
REQ-016 rdata  out  16  latched read data, shared by both ports.
REQ-017 busy  out  1  access in progress (any state other than IDLE).

Function
REQ-018 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD; every access SHALL take exactly 4 cycles: IDLE(grant) -> SETUP -> STROBE -> HOLD -> IDLE.
REQ-019 In IDLE with blr_=1 and at least one request, the block SHALL grant and latch reg, we and wdata of the winner on that edge, then enter SETUP.
REQ-020 In IDLE with blr_=0, the block SHALL grant nothing and remain in IDLE.
REQ-021 Arbitration SHALL grant the CPU when only the CPU requests, and the panel when only the panel requests.
REQ-022 When both request, the block SHALL grant the CPU unless streak==CP_STARVE, in which case it SHALL grant the panel.
REQ-023 The 3-bit counter streak SHALL increment on a CPU grant made while cp_req=1 (saturating at CP_STARVE), and SHALL clear on a panel grant or on a CPU grant with cp_req=0.
REQ-024 In SETUP, STROBE and HOLD, the select outputs SHALL hold the latched index, w SHALL equal the latched wdata, and w_r_ SHALL equal ~we.
REQ-025 strob1_ SHALL be low in STROBE only.
REQ-026 On a read, rdata SHALL load l at the edge leaving STROBE; on a write, rdata SHALL be unchanged.
REQ-027 In HOLD, the winner's ack SHALL be high for exactly that one cycle; the other ack SHALL stay low; the two acks SHALL never be high together.
REQ-028 A requester SHALL drop req in the cycle after ack; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-029 blr_ falling during SETUP, STROBE or HOLD SHALL NOT abort the access; the access SHALL complete, and grants SHALL resume when blr_ returns high.
REQ-030 Request input changes after a grant SHALL NOT affect the access in flight.
REQ-031 In IDLE, outputs SHALL be: ra_=rb_=rc_=1, w_r_=1, strob1_=1, w=0, busy=0, acks=0.
REQ-032 Index 0 (R0) SHALL be accessed like any other register; the block SHALL give R0 no special treatment.

Reset
REQ-033 While clm_=0, regardless of clock: state=IDLE, streak=0, rdata=0x0000, latched reg/we/wdata=0, and all outputs at their IDLE values.
REQ-034 clm_ asserted mid-access SHALL abort the access immediately with no ack; after release, the first grant SHALL occur no earlier than the first rising edge with clm_=1.

Verification
REQ-035 CPU read R3 with l=0xA5C3 and panel idle -> ra_=0, rb_=0, rc_=1 for 3 cycles; strob1_ low 1 cycle; rdata=0xA5C3 and cpu_ack pulse in HOLD; w_r_ stays 1.
REQ-036 Panel write R7=0x1234 -> w=0x1234 and w_r_=0 during SETUP..HOLD; ra_=rb_=rc_=0; cp_ack pulse in the 4th cycle; rdata unchanged.
REQ-037 cpu_req and cp_req held continuously with CP_STARVE=4 -> grant order CPU,CPU,CPU,CPU,PANEL repeating; an ack every 4 cycles; acks never both high.
REQ-038 blr_=0 with both requests pending for 10 cycles -> busy=0 and no acks; blr_ taken low during STROBE -> that access still acks in HOLD, then no new grant until blr_=1.
REQ-039 clm_ pulsed low during STROBE of a CPU read -> no cpu_ack; rdata=0x0000; outputs at IDLE values; with cpu_req still high, a new grant occurs on the first edge after release.

Source files
------------

// File: rtl/pr_arb.sv
// Register-file access arbiter between the CPU and the control panel.
// Each access runs through a fixed four-cycle IDLE/SETUP/STROBE/HOLD sequence.
module pr_arb #(
  parameter int CP_STARVE = 4
) (
  input  logic        clk_sys,
  input  logic        clm_,
  input  logic        blr_,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_reg,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  input  logic        cp_req,
  input  logic        cp_we,
  input  logic [2:0]  cp_reg,
  input  logic [15:0] cp_wdata,
  output logic        cp_ack,
  input  logic [15:0] l,
  output logic [15:0] w,
  output logic        ra_,
  output logic        rb_,
  output logic        rc_,
  output logic        w_r_,
  output logic        strob1_,
  output logic [15:0] rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3} state_t;

  localparam logic [2:0] STARVE = 3'(CP_STARVE);

  state_t      state_q, state_d;
  logic [2:0]  streak_q, streak_d;
  logic [2:0]  reg_q, reg_d;
  logic        we_q, we_d;
  logic        win_cp_q, win_cp_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        grant_cp;

  always_ff @(posedge clk_sys or negedge clm_) begin
    if (!clm_) begin
      state_q  <= IDLE;
      streak_q <= '0;
      reg_q    <= '0;
      we_q     <= 1'b0;
      win_cp_q <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      reg_q    <= reg_d;
      we_q     <= we_d;
      win_cp_q <= win_cp_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    reg_d    = reg_q;
    we_d     = we_q;
    win_cp_d = win_cp_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    grant_cp = 1'b0;
    case (state_q)
      IDLE: begin
        if (blr_ && (cpu_req || cp_req)) begin
          // The panel wins a contested grant only once the CPU streak has hit the limit.
          grant_cp = cp_req && (!cpu_req || (streak_q == STARVE));
          win_cp_d = grant_cp;
          reg_d    = grant_cp ? cp_reg    : cpu_reg;
          we_d     = grant_cp ? cp_we     : cpu_we;
          wdata_d  = grant_cp ? cp_wdata  : cpu_wdata;
          if (grant_cp || !cp_req) begin
            streak_d = '0;
          end else if (streak_q != STARVE) begin
            streak_d = streak_q + 3'd1;
          end
          state_d = SETUP;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: begin
        if (!we_q) begin
          rdata_d = l;
        end
        state_d = HOLD;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    w       = '0;
    ra_     = 1'b1;
    rb_     = 1'b1;
    rc_     = 1'b1;
    w_r_    = 1'b1;
    strob1_ = 1'b1;
    cpu_ack = 1'b0;
    cp_ack  = 1'b0;
    busy    = (state_q != IDLE);
    if (state_q != IDLE) begin
      {rc_, rb_, ra_} = ~reg_q;
      w               = wdata_q;
      w_r_            = ~we_q;
      strob1_         = (state_q != STROBE);
      cpu_ack         = (state_q == HOLD) && !win_cp_q;
      cp_ack          = (state_q == HOLD) && win_cp_q;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_pr_arb.sv
// Bench for pr_arb: directed scenarios followed by random traffic, all outputs
// compared every cycle against a transaction-level reference model.
module tb_pr_arb;

  localparam int CP_STARVE = 4;

  logic        clk_sys = 1'b0;
  logic        clm_, blr_;
  logic        cpu_req, cpu_we, cp_req, cp_we;
  logic [2:0]  cpu_reg, cp_reg;
  logic [15:0] cpu_wdata, cp_wdata, l;
  logic        cpu_ack, cp_ack;
  logic [15:0] w, rdata;
  logic        ra_, rb_, rc_, w_r_, strob1_, busy;

  int total = 0;
  int bad   = 0;

  pr_arb #(.CP_STARVE(CP_STARVE)) dut (
    .clk_sys(clk_sys), .clm_(clm_), .blr_(blr_),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_reg(cpu_reg), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .cp_req(cp_req), .cp_we(cp_we), .cp_reg(cp_reg), .cp_wdata(cp_wdata), .cp_ack(cp_ack),
    .l(l), .w(w), .ra_(ra_), .rb_(rb_), .rc_(rc_), .w_r_(w_r_), .strob1_(strob1_),
    .rdata(rdata), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Reference model: cycles elapsed within the current access (0 = idle) plus the
  // parameters of the winning request.
  int          m_phase;
  int          m_streak;
  logic        m_win_cp;
  logic [2:0]  m_reg;
  logic        m_we;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;

  task automatic model_reset();
    m_phase  = 0;
    m_streak = 0;
    m_win_cp = 1'b0;
    m_reg    = 3'd0;
    m_we     = 1'b0;
    m_wdata  = 16'h0000;
    m_rdata  = 16'h0000;
  endtask

  task automatic model_edge();
    if (!clm_) begin
      model_reset();
    end else if (m_phase == 0) begin
      if (blr_ && (cpu_req || cp_req)) begin
        m_win_cp = cp_req && (!cpu_req || m_streak == CP_STARVE);
        if (m_win_cp)     m_streak = 0;
        else if (cp_req)  m_streak = (m_streak + 1 > CP_STARVE) ? CP_STARVE : m_streak + 1;
        else              m_streak = 0;
        m_reg   = m_win_cp ? cp_reg   : cpu_reg;
        m_we    = m_win_cp ? cp_we    : cpu_we;
        m_wdata = m_win_cp ? cp_wdata : cpu_wdata;
        m_phase = 1;
      end
    end else begin
      if (m_phase == 2 && !m_we) m_rdata = l;
      m_phase = (m_phase + 1) % 4;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    logic [7:0] exp_ctl;
    logic [2:0] sel;
    sel = (m_phase != 0) ? ~m_reg : 3'b111;
    exp_ctl = {m_phase != 0, sel,
               (m_phase != 0) ? ~m_we : 1'b1,
               m_phase != 2,
               (m_phase == 3) && !m_win_cp,
               (m_phase == 3) && m_win_cp};
    chk({where, "/ctl"}, 32'({busy, rc_, rb_, ra_, w_r_, strob1_, cpu_ack, cp_ack}), 32'(exp_ctl));
    chk({where, "/w"}, 32'(w), 32'((m_phase != 0) ? m_wdata : 16'h0000));
    chk({where, "/rdata"}, 32'(rdata), 32'(m_rdata));
    chk({where, "/ack_excl"}, 32'(cpu_ack & cp_ack), 32'(0));
  endtask

  // Inputs are set at the falling edge; the model follows each rising edge and
  // outputs are compared at the next falling edge.
  task automatic tick(input string where);
    @(posedge clk_sys);
    model_edge();
    @(negedge clk_sys);
    check_all(where);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   grants[$];
    int   pattern[10];
    int   n;
    clm_ = 1'b0; blr_ = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_reg = 3'd0; cpu_wdata = 16'h0;
    cp_req  = 1'b0; cp_we  = 1'b0; cp_reg  = 3'd0; cp_wdata  = 16'h0;
    l = 16'h0;
    model_reset();
    #2 check_all("reset_async");
    @(negedge clk_sys);
    cpu_req = 1'b1; cp_req = 1'b1;
    tick("reset_held");
    tick("reset_held");
    cpu_req = 1'b0; cp_req = 1'b0;
    clm_ = 1'b1;
    tick("idle");

    // CPU read of R3
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_reg = 3'd3; cpu_wdata = 16'h5555; l = 16'hA5C3;
    tick("rd_setup");
    chk("rd_sel", 32'({rc_, rb_, ra_}), 32'(3'b100));
    cpu_req = 1'b0;
    tick("rd_strobe");
    chk("rd_strobe_low", 32'(strob1_), 32'(0));
    tick("rd_hold");
    chk("rd_rdata", 32'(rdata), 32'(16'hA5C3));
    chk("rd_ack", 32'({cpu_ack, cp_ack, w_r_}), 32'(3'b101));
    l = 16'h0F0F;
    tick("rd_idle");

    // Panel write of R7
    cp_req = 1'b1; cp_we = 1'b1; cp_reg = 3'd7; cp_wdata = 16'h1234;
    tick("wr_setup");
    chk("wr_w", 32'({w, w_r_, rc_, rb_, ra_}), 32'({16'h1234, 4'b0000}));
    cp_req = 1'b0; cp_wdata = 16'hDEAD; cp_reg = 3'd1;
    tick("wr_strobe");
    tick("wr_hold");
    chk("wr_ack", 32'({cp_ack, cpu_ack}), 32'(2'b10));
    chk("wr_rdata_kept", 32'(rdata), 32'(16'hA5C3));
    tick("wr_idle");

    // CPU write of R0
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_reg = 3'd0; cpu_wdata = 16'hFFFF;
    tick("r0_setup");
    chk("r0_w", 32'({w, w_r_, busy}), 32'({16'hFFFF, 2'b01}));
    cpu_req = 1'b0;
    repeat (3) tick("r0_rest");

    // Both requesting continuously: four CPU grants, then one panel grant
    cpu_req = 1'b1; cp_req = 1'b1; cpu_we = 1'b0; cp_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cpu_reg = 3'($urandom_range(0, 7)); cp_reg = 3'($urandom_range(0, 7));
      l = 16'($urandom);
      tick("starve");
      if (cpu_ack) grants.push_back(0);
      if (cp_ack)  grants.push_back(1);
    end
    pattern = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    n = grants.size();
    chk("starve_count", 32'(n), 32'(10));
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("starve_order%0d", i), 32'((i < n) ? grants[i] : 9), 32'(pattern[i]));
    end

    // Register block inhibits grants but never aborts an access in flight
    blr_ = 1'b0;
    for (int i = 0; i < 10; i++) tick("blr_low");
    chk("blr_low_busy", 32'({busy, cpu_ack, cp_ack}), 32'(0));
    blr_ = 1'b1;
    tick("blr_grant");
    tick("blr_strobe");
    blr_ = 1'b0;
    tick("blr_hold");
    chk("blr_hold_ack", 32'(cpu_ack), 32'(1));
    for (int i = 0; i < 4; i++) tick("blr_inhibit");
    chk("blr_inhibit_busy", 32'(busy), 32'(0));
    blr_ = 1'b1;
    tick("blr_resume");
    chk("blr_resume_busy", 32'(busy), 32'(1));
    cpu_req = 1'b0; cp_req = 1'b0;
    repeat (3) tick("blr_drain");

    // Reset pulse during STROBE of a CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_reg = 3'd5; l = 16'hBEEF;
    tick("rst_setup");
    tick("rst_strobe");
    clm_ = 1'b0;
    #1 model_reset();
    check_all("rst_async");
    chk("rst_rdata", 32'({rdata, busy}), 32'(0));
    tick("rst_held");
    chk("rst_noack", 32'({cpu_ack, cp_ack}), 32'(0));
    clm_ = 1'b1;
    tick("rst_regrant");
    chk("rst_regrant_busy", 32'(busy), 32'(1));
    cpu_req = 1'b0;
    repeat (3) tick("rst_drain");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cpu_req   = ($urandom_range(0, 2) != 0);
      cp_req    = ($urandom_range(0, 2) != 0);
      cpu_we    = 1'($urandom);
      cp_we     = 1'($urandom);
      cpu_reg   = 3'($urandom);
      cp_reg    = 3'($urandom);
      cpu_wdata = 16'($urandom);
      cp_wdata  = 16'($urandom);
      l         = 16'($urandom);
      blr_      = ($urandom_range(0, 7) != 0);
      tick("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
